// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO. Multiplies finish after a fixed
// latency; divides use one restoring step per cycle followed by a sign-fix cycle.
module mdu_iter #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [2:0]       MDUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int CNT_MAX = (MULT_CYCLES > WIDTH) ? MULT_CYCLES - 1 : WIDTH - 1;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     rem, quo, dvs;
   logic                 neg_q, neg_r, dz;

   // Signed ops have an even opcode; the same flag serves MULT and DIV.
   logic                 is_signed, a_neg, b_neg;
   logic [2*WIDTH-1:0]   ax, bx, prod_next;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic [WIDTH:0]       shifted, trial;
   logic                 ge;
   logic [WIDTH-1:0]     rem_step, quo_step, q_fix, r_fix;

   assign is_signed = ~MDUOp[0];
   assign a_neg     = is_signed & A[WIDTH-1];
   assign b_neg     = is_signed & B[WIDTH-1];

   // Extending to 2*WIDTH makes the truncated product correct for both signednesses.
   assign ax        = {{WIDTH{a_neg}}, A};
   assign bx        = {{WIDTH{b_neg}}, B};
   assign prod_next = ax * bx;

   assign a_abs = a_neg ? -A : A;
   assign b_abs = b_neg ? -B : B;

   // Restoring step: dividend bits shift out of quo's MSB into the remainder.
   assign shifted  = {rem, quo[WIDTH-1]};
   assign trial    = shifted - {1'b0, dvs};
   assign ge       = ~trial[WIDTH];
   assign rem_step = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_step = {quo[WIDTH-2:0], ge};

   assign q_fix = neg_q ? -quo : quo;
   assign r_fix = neg_r ? -rem : rem;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         cnt   <= '0;
         prod  <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         HI    <= '0;
         LO    <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  case (MDUOp)
                     OP_MTHI: HI <= A;
                     OP_MTLO: LO <= A;
                     OP_MULT, OP_MULTU: begin
                        prod  <= prod_next;
                        cnt   <= CW'(MULT_CYCLES - 1);
                        Busy  <= 1'b1;
                        state <= MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        quo   <= a_abs;
                        dvs   <= b_abs;
                        rem   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz    <= (B == '0);
                        cnt   <= CW'(WIDTH - 1);
                        Busy  <= 1'b1;
                        state <= DIV;
                     end
                     default: ;
                  endcase
               end
            end
            MUL: begin
               if (cnt == '0) begin
                  {HI, LO} <= prod;
                  Busy     <= 1'b0;
                  Done     <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DIV: begin
               rem <= rem_step;
               quo <= quo_step;
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - CW'(1);
            end
            FIX: begin
               // Divide by zero still takes full latency but leaves HI/LO alone.
               if (!dz) begin
                  LO <= q_fix;
                  HI <= r_fix;
               end
               Busy  <= 1'b0;
               Done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined CPU. Sits beside the ALU in EX and owns the HI/LO registers. Executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and MTHI/MTLO in one cycle. Raises `Busy` so the hazard logic can stall any later MDU instruction or MFHI/MFLO.

## Interface

Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Must be ≥ 4 and even.
- `MULT_CYCLES`, default 5: multiply latency in cycles. Must be ≥ 1.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: launch the operation in `MDUOp`. Honoured only when `Busy`=0.
- `MDUOp`, in, 3: operation select.
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `A`, in, WIDTH: rs operand (multiplicand, dividend, or MT source).
- `B`, in, WIDTH: rt operand (multiplier or divisor).
- `Busy`, out, 1: multi-cycle operation in flight.
- `Done`, out, 1: one-cycle pulse; HI/LO have just been updated by a MULT/DIV.
- `HI`, out, WIDTH: HI register.
- `LO`, out, WIDTH: LO register.

## Operation

- States: IDLE, MUL, DIV, FIX.
- Reset values: state IDLE; `Busy`=0, `Done`=0, `HI`=0, `LO`=0; counter=0.
- IDLE, on `Start`=1:
  - MTHI writes `HI`<=`A`; MTLO writes `LO`<=`A`. State stays IDLE, `Busy` stays 0.
  - MULT/MULTU capture the full 2·WIDTH product, signed or unsigned as selected, into an internal register. Load counter=`MULT_CYCLES`-1 and go to MUL.
  - DIV/DIVU capture |A| and |B| (raw values for DIVU) plus the sign flags. Counter=WIDTH-1. Go to DIV.
  - Ops 110/111: nothing happens.
- MUL: decrement the counter each cycle. When counter=0: `{HI,LO}`<=product, go to IDLE, pulse `Done`.
- DIV: one restoring-division step per cycle, producing 1 quotient bit and a partial remainder. After the step with counter=0, go to FIX.
- FIX: apply signs (DIV only).
  - Quotient is negated if the operand signs differ, so it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - `LO`<=quotient, `HI`<=remainder. Go to IDLE, pulse `Done`.
- Divide by zero (`B`=0): the full latency still elapses and `Done` still pulses, but HI/LO keep their prior values.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): `LO`=2^(WIDTH-1) bit pattern, `HI`=0. This is the natural wrap.
- `Start` while `Busy`=1 is ignored, including MTHI/MTLO. Operands are not re-sampled.
- `Rst` at any point aborts the operation and restores all reset values.
- `A`/`B` are sampled only at the accept edge. Later changes have no effect.

## Timing

- Accept edge t is the edge where `Start`=1 and `Busy`=0.
- MULT/MULTU:
  - `Busy`=1 for the cycles after edges t … t+`MULT_CYCLES`-1.
  - HI/LO update at edge t+`MULT_CYCLES`.
  - `Busy`=0 and `Done`=1 during the cycle after that edge.
- DIV/DIVU:
  - Same pattern with latency WIDTH+1: WIDTH step cycles plus FIX.
  - `Done` is high the cycle after edge t+WIDTH+1.
- MTHI/MTLO: register updates at edge t. `Busy` and `Done` stay 0.
- Back-to-back: `Start` may be asserted in the same cycle `Done`=1, since `Busy` is already 0 then. It is accepted at that cycle's edge with no dead cycle.
- `Busy` and `Done` are registered; there are no combinational paths from inputs to outputs.

## Test plan

Defaults throughout: WIDTH=32, MULT_CYCLES=5.

- MULTU, A=0xFFFFFFFF, B=2 -> `Busy` for 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE, `Done` for 1 cycle.
- MULT, A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MTHI A=0x12345678 -> next cycle HI=0x12345678, LO unchanged, `Busy`=0.
- DIV, A=-7, B=2 -> `Busy` for 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU, A=5, B=2 -> LO=2, HI=1.
- DIVU with B=0, prior HI/LO = 0xAA/0xBB -> after 33 cycles HI/LO are still 0xAA/0xBB and `Done` pulses.
- Busy/reset corner cases:
  - `Start` MULTU (3×4) asserted mid-DIV -> ignored; the DIV result is unaffected.
  - `Rst` at cycle 10 of a DIV -> the next cycle shows `Busy`=0, HI=LO=0, no `Done`.
